// File: rtl/segment_pool_classifier.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : segment_pool_classifier                                |
// | Segment average pooling, sequential dense layer, argmax result.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module segment_pool_classifier #(
  parameter int DATA_WIDTH  = 16,
  parameter int COEF_WIDTH  = 16,
  parameter int ACC_WIDTH   = 48,
  parameter int WINDOW_SIZE = 32,
  parameter int NUM_SEG     = 4,
  parameter int NUM_CLASSES = 4,
  parameter logic signed [COEF_WIDTH-1:0] WEIGHTS [NUM_CLASSES][NUM_SEG] = '{
    '{16'sd1, 16'sd0, 16'sd0, 16'sd0},
    '{16'sd0, 16'sd1, 16'sd0, 16'sd0},
    '{16'sd0, 16'sd0, 16'sd1, 16'sd0},
    '{16'sd0, 16'sd0, 16'sd0, 16'sd1}},
  parameter logic signed [COEF_WIDTH-1:0] BIASES [NUM_CLASSES] = '{default: '0}
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [DATA_WIDTH-1:0]   x_in,
  input  logic                           x_valid,
  output logic                           cls_valid,
  input  logic                           cls_ready,
  output logic [$clog2(NUM_CLASSES)-1:0] cls_idx,
  output logic signed [ACC_WIDTH-1:0]    cls_score,
  output logic [7:0]                     drop_count
);

  localparam int c_SEG_LEN = WINDOW_SIZE / NUM_SEG;
  localparam int c_SHIFT   = $clog2(c_SEG_LEN);
  localparam int c_CNT_W   = $clog2(WINDOW_SIZE);
  localparam int c_IDX_W   = $clog2(NUM_CLASSES);
  localparam int c_SEG_W   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  localparam int c_PROD_W  = DATA_WIDTH + COEF_WIDTH;
  localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(WINDOW_SIZE - 1);
  localparam logic [c_SEG_W-1:0] c_LAST_SEG = c_SEG_W'(NUM_SEG - 1);
  localparam logic [c_IDX_W-1:0] c_LAST_CLS = c_IDX_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_MAC  = 2'd1,
    D_OUT  = 2'd2
  } state_t;

  // ---------------- pooling ----------------
  logic [c_CNT_W-1:0]           r_samp_cnt;
  logic signed [ACC_WIDTH-1:0]  r_seg_acc;
  logic signed [DATA_WIDTH-1:0] r_stage [NUM_SEG];

  logic signed [ACC_WIDTH-1:0]  w_sample_ext;
  logic signed [ACC_WIDTH-1:0]  w_acc_sum;
  logic signed [ACC_WIDTH-1:0]  w_acc_shift;
  logic signed [DATA_WIDTH-1:0] w_feature;
  logic signed [DATA_WIDTH-1:0] w_stage_next [NUM_SEG];
  logic                         w_seg_end;
  logic                         w_win_end;
  int                           w_seg_idx;

  always_comb begin
    w_sample_ext = {{(ACC_WIDTH-DATA_WIDTH){x_in[DATA_WIDTH-1]}}, x_in};
    w_acc_sum    = r_seg_acc + w_sample_ext;
    w_acc_shift  = w_acc_sum >>> c_SHIFT;
    w_feature    = w_acc_shift[DATA_WIDTH-1:0];
    w_seg_idx    = int'(r_samp_cnt) / c_SEG_LEN;
    w_seg_end    = (int'(r_samp_cnt) % c_SEG_LEN) == (c_SEG_LEN - 1);
    w_win_end    = x_valid && (r_samp_cnt == c_LAST_CNT);
    // Staging view including the feature completing this cycle, so the
    // window's last segment reaches the feature registers on the same edge.
    for (int s = 0; s < NUM_SEG; s++) begin
      w_stage_next[s] = r_stage[s];
      if (x_valid && w_seg_end && (s == w_seg_idx))
        w_stage_next[s] = w_feature;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_samp_cnt <= '0;
      r_seg_acc  <= '0;
      for (int s = 0; s < NUM_SEG; s++) r_stage[s] <= '0;
    end else if (x_valid) begin
      r_samp_cnt <= w_win_end ? '0 : r_samp_cnt + c_CNT_W'(1);
      r_seg_acc  <= w_seg_end ? '0 : w_acc_sum;
      for (int s = 0; s < NUM_SEG; s++) r_stage[s] <= w_stage_next[s];
    end
  end

  // ---------------- dense layer + argmax ----------------
  state_t                       r_state;
  logic [c_IDX_W-1:0]           r_c;
  logic [c_SEG_W-1:0]           r_s;
  logic signed [ACC_WIDTH-1:0]  r_mac_acc;
  logic signed [ACC_WIDTH-1:0]  r_best_score;
  logic [c_IDX_W-1:0]           r_best_idx;
  logic signed [DATA_WIDTH-1:0] r_feat [NUM_SEG];

  logic signed [c_PROD_W-1:0]   w_prod;
  logic signed [ACC_WIDTH-1:0]  w_prod_ext;
  logic signed [ACC_WIDTH-1:0]  w_bias_ext;
  logic signed [ACC_WIDTH-1:0]  w_mac_base;
  logic signed [ACC_WIDTH-1:0]  w_mac_sum;
  logic                         w_take;
  logic                         w_last_seg;
  logic                         w_last_cls;

  always_comb begin
    w_prod     = r_feat[r_s] * WEIGHTS[r_c][r_s];
    w_prod_ext = {{(ACC_WIDTH-c_PROD_W){w_prod[c_PROD_W-1]}}, w_prod};
    w_bias_ext = {{(ACC_WIDTH-COEF_WIDTH){BIASES[r_c][COEF_WIDTH-1]}}, BIASES[r_c]};
    w_mac_base = (r_s == '0) ? w_bias_ext : r_mac_acc;
    w_mac_sum  = w_mac_base + w_prod_ext;
    // Strict compare keeps ties on the lowest class index.
    w_take     = (r_c == '0) || (w_mac_sum > r_best_score);
    w_last_seg = (r_s == c_LAST_SEG);
    w_last_cls = (r_c == c_LAST_CLS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= D_IDLE;
      r_c          <= '0;
      r_s          <= '0;
      r_mac_acc    <= '0;
      r_best_score <= '0;
      r_best_idx   <= '0;
      for (int s = 0; s < NUM_SEG; s++) r_feat[s] <= '0;
      cls_valid    <= 1'b0;
      cls_idx      <= '0;
      cls_score    <= '0;
      drop_count   <= '0;
    end else begin
      if (w_win_end) begin
        if (r_state == D_IDLE) begin
          for (int s = 0; s < NUM_SEG; s++) r_feat[s] <= w_stage_next[s];
        end else if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 8'd1;
        end
      end

      case (r_state)
        D_IDLE: begin
          if (w_win_end) begin
            r_state <= D_MAC;
            r_c     <= '0;
            r_s     <= '0;
          end
        end
        D_MAC: begin
          r_mac_acc <= w_mac_sum;
          if (w_last_seg) begin
            r_s <= '0;
            if (w_take) begin
              r_best_score <= w_mac_sum;
              r_best_idx   <= r_c;
            end
            if (w_last_cls) begin
              r_state   <= D_OUT;
              cls_valid <= 1'b1;
              cls_idx   <= w_take ? r_c : r_best_idx;
              cls_score <= w_take ? w_mac_sum : r_best_score;
            end else begin
              r_c <= r_c + c_IDX_W'(1);
            end
          end else begin
            r_s <= r_s + c_SEG_W'(1);
          end
        end
        D_OUT: begin
          if (cls_ready) begin
            r_state   <= D_IDLE;
            cls_valid <= 1'b0;
          end
        end
        default: r_state <= D_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_segment_pool_classifier.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_segment_pool_classifier                             |
// | Scoreboard bench for segment_pool_classifier.                    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_segment_pool_classifier;

  localparam int DW     = 16;
  localparam int AW     = 48;
  localparam int WIN    = 32;
  localparam int NSEG   = 4;
  localparam int NCLS   = 4;
  localparam int SEGLEN = WIN / NSEG;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [DW-1:0] x_in = '0;
  logic                 x_valid = 1'b0;
  logic                 cls_valid;
  logic                 cls_ready = 1'b1;
  logic [1:0]           cls_idx;
  logic signed [AW-1:0] cls_score;
  logic [7:0]           drop_count;

  always #5 clk = ~clk;

  segment_pool_classifier dut (
    .clk        (clk),
    .rst        (rst),
    .x_in       (x_in),
    .x_valid    (x_valid),
    .cls_valid  (cls_valid),
    .cls_ready  (cls_ready),
    .cls_idx    (cls_idx),
    .cls_score  (cls_score),
    .drop_count (drop_count)
  );

  typedef struct {
    longint idx;
    longint score;
  } exp_t;

  exp_t   sb_q[$];
  exp_t   mon_e;
  int     n_cmp = 0;
  int     n_err = 0;
  int     win[WIN];
  bit     hold_armed = 1'b0;
  longint hold_idx;
  longint hold_score;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill(input int a, input int b, input int c, input int d);
    int v[NSEG];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < WIN; i++) win[i] = v[i / SEGLEN];
  endtask

  // Reference: floor average per segment, identity dense layer, zero bias.
  task automatic push_expected();
    longint feat[NSEG];
    longint score[NCLS];
    longint sum, r;
    exp_t   e;
    for (int s = 0; s < NSEG; s++) begin
      sum = 0;
      for (int k = 0; k < SEGLEN; k++) sum += win[s*SEGLEN + k];
      r = ((sum % SEGLEN) + SEGLEN) % SEGLEN;
      feat[s] = (sum - r) / SEGLEN;
    end
    for (int c = 0; c < NCLS; c++) begin
      score[c] = 0;
      for (int s = 0; s < NSEG; s++) score[c] += (c == s) ? feat[s] : 0;
    end
    e.idx = 0;
    e.score = score[0];
    for (int c = 1; c < NCLS; c++)
      if (score[c] > e.score) begin
        e.idx = c;
        e.score = score[c];
      end
    sb_q.push_back(e);
  endtask

  task automatic send_window(input bit accept);
    for (int i = 0; i < WIN; i++) begin
      x_in    = DW'(win[i]);
      x_valid = 1'b1;
      @(posedge clk); #1;
    end
    x_valid = 1'b0;
    if (accept) push_expected();
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb_q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    check("drain_timeout", sb_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Output monitor: pops the scoreboard on each handshake and checks stall stability.
  always @(negedge clk) begin
    if (rst) begin
      hold_armed = 1'b0;
    end else begin
      if (hold_armed) begin
        check("hold_valid", cls_valid, 1);
        check("hold_idx", cls_idx, hold_idx);
        check("hold_score", $signed(cls_score), hold_score);
      end
      if (cls_valid && cls_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check("res_idx", cls_idx, mon_e.idx);
          check("res_score", $signed(cls_score), mon_e.score);
        end
      end
      hold_armed = cls_valid && !cls_ready;
      hold_idx   = cls_idx;
      hold_score = $signed(cls_score);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", cls_valid, 0);
    check("rst_idx", cls_idx, 0);
    check("rst_score", $signed(cls_score), 0);
    check("rst_drop", drop_count, 0);

    // Constant 8: all-tie, latency 17 cycles, single-cycle pulse
    cls_ready = 1'b1;
    fill(8, 8, 8, 8);
    send_window(1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("t1_lat_low", cls_valid, 0);
    end
    @(negedge clk);
    check("t1_lat_high", cls_valid, 1);
    @(negedge clk);
    check("t1_pulse", cls_valid, 0);
    wait_drain();
    check("t1_drop", drop_count, 0);

    fill(1, 5, 3, 2);
    send_window(1);
    wait_drain();

    fill(-4, -4, -4, -1);
    send_window(1);
    wait_drain();

    // Floor pooling: seven zeros and one -1 average to -1
    fill(0, -2, -3, -5);
    win[7] = -1;
    send_window(1);
    wait_drain();

    // Backpressure with a dropped back-to-back window
    cls_ready = 1'b0;
    fill(1, 5, 3, 2);
    send_window(1);
    fill(1, 2, 9, 0);
    send_window(0);
    repeat (4) @(posedge clk);
    #1;
    check("t4_drop", drop_count, 1);
    check("t4_valid", cls_valid, 1);
    check("t4_idx", cls_idx, 1);
    check("t4_score", $signed(cls_score), 5);
    cls_ready = 1'b1;
    wait_drain();
    check("t4_after_hs", cls_valid, 0);

    // Partial window discarded by reset
    for (int i = 0; i < 10; i++) begin
      x_in = DW'(9);
      x_valid = 1'b1;
      @(posedge clk); #1;
    end
    x_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_drop_rst", drop_count, 0);
    fill(2, 2, 2, 2);
    send_window(1);
    wait_drain();
    check("t5_drop", drop_count, 0);
    check("t5_idle", cls_valid, 0);

    // Drop counter saturation while a result is held
    cls_ready = 1'b0;
    fill(0, 0, 6, 0);
    send_window(1);
    fill(1, 2, 3, 4);
    for (int w = 0; w < 299; w++) send_window(0);
    repeat (2) @(posedge clk);
    #1;
    check("t6_drop_sat", drop_count, 255);
    check("t6_valid", cls_valid, 1);
    check("t6_idx", cls_idx, 2);
    check("t6_score", $signed(cls_score), 6);
    cls_ready = 1'b1;
    wait_drain();
    check("t6_after_hs", cls_valid, 0);
    check("t6_drop_kept", drop_count, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
